// File: rtl/ctr_run_arbiter.sv
// Round-robin sequencer sharing one up/down counter between NREQ requesters.
// Optional watchdog on stalled runs: define CTR_RUN_WATCHDOG_EN.
module ctr_run_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   start_val,
  input  logic [NREQ*WIDTH-1:0]   target_val,
  input  logic                    abort,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                    aborted,
  output logic                    err,
  output logic                    ctr_load,
  output logic                    ctr_enable,
  output logic                    ctr_up_down,
  output logic [WIDTH-1:0]        ctr_d_in,
  input  logic [WIDTH-1:0]        ctr_count
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr, rr_nx;
  logic [IDW-1:0]   win_idx, ptr_after;
  logic             win_found;
  logic [WIDTH-1:0] win_start, win_target;
  logic [WIDTH-1:0] tgt_q, tgt_nx;
  logic             stop_hit;

  logic [NREQ-1:0]  gnt_nx;
  logic             busy_nx, done_nx, aborted_nx;
  logic [IDW-1:0]   id_nx;
  logic             load_nx, enable_nx, up_nx;
  logic [WIDTH-1:0] d_nx;

  // First requester at or above rr_ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      if (!win_found && req[(32'(rr_ptr) + off) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IDW'((32'(rr_ptr) + off) % NREQ);
      end
    end
  end

  assign win_start  = start_val[win_idx*WIDTH +: WIDTH];
  assign win_target = target_val[win_idx*WIDTH +: WIDTH];
  assign ptr_after  = (done_id == IDW'(NREQ - 1)) ? '0 : done_id + 1'b1;

  // Stop one step early so the registered enable drops on the edge that reaches target
  assign stop_hit = ctr_up_down ? (ctr_count == tgt_q - WIDTH'(1))
                                : (ctr_count == tgt_q + WIDTH'(1));

`ifdef CTR_RUN_WATCHDOG_EN
  logic [WIDTH:0] wd_cnt;
  logic           wd_trip;
  logic           err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == S_LOAD) begin
      wd_cnt <= '0;
    end else if (state == S_RUN) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_trip = (state == S_RUN) && (wd_cnt == {1'b1, {WIDTH{1'b0}}});
`endif

  always_comb begin
    state_nx   = state;
    rr_nx      = rr_ptr;
    tgt_nx     = tgt_q;
    gnt_nx     = '0;
    busy_nx    = busy;
    done_nx    = 1'b0;
    id_nx      = done_id;
    aborted_nx = 1'b0;
    load_nx    = 1'b0;
    enable_nx  = ctr_enable;
    up_nx      = ctr_up_down;
    d_nx       = ctr_d_in;
`ifdef CTR_RUN_WATCHDOG_EN
    err_nx     = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nx  = S_LOAD;
          gnt_nx    = NREQ'(1) << win_idx;
          busy_nx   = 1'b1;
          load_nx   = 1'b1;
          enable_nx = 1'b0;
          d_nx      = win_start;
          up_nx     = (win_target >= win_start);
          id_nx     = win_idx;
          tgt_nx    = win_target;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nx   = S_IDLE;
          busy_nx    = 1'b0;
          enable_nx  = 1'b0;
          aborted_nx = 1'b1;
          rr_nx      = ptr_after;
        end else if (tgt_q == ctr_d_in) begin
          state_nx  = S_DONE;
          enable_nx = 1'b0;
          done_nx   = 1'b1;
        end else begin
          state_nx  = S_RUN;
          enable_nx = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nx   = S_IDLE;
          busy_nx    = 1'b0;
          enable_nx  = 1'b0;
          aborted_nx = 1'b1;
          rr_nx      = ptr_after;
        end else if (stop_hit) begin
          state_nx  = S_DONE;
          enable_nx = 1'b0;
          done_nx   = 1'b1;
        end
`ifdef CTR_RUN_WATCHDOG_EN
        else if (wd_trip) begin
          state_nx  = S_IDLE;
          busy_nx   = 1'b0;
          enable_nx = 1'b0;
          err_nx    = 1'b1;
          rr_nx     = ptr_after;
        end
`endif
      end
      S_DONE: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
        rr_nx    = ptr_after;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      tgt_q       <= '0;
      gnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      aborted     <= 1'b0;
      ctr_load    <= 1'b0;
      ctr_enable  <= 1'b0;
      ctr_up_down <= 1'b1;
      ctr_d_in    <= '0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_nx;
      tgt_q       <= tgt_nx;
      gnt         <= gnt_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      done_id     <= id_nx;
      aborted     <= aborted_nx;
      ctr_load    <= load_nx;
      ctr_enable  <= enable_nx;
      ctr_up_down <= up_nx;
      ctr_d_in    <= d_nx;
    end
  end

`ifdef CTR_RUN_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_nx;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/ctr_run_arbiter.md
Name: ctr_run_arbiter

Overview:
- Sequencer and arbiter that shares one updown_counter between NREQ requesters.
- Each requester asks for a "run": load start_val, then count up or down until target_val, then stop.
- Drives the counter's load, enable, up_down and d_in pins, and observes its count output.
- Round-robin arbitration; one run in flight at a time.

Parameters:
WIDTH, 4, counter data width (matches counter d_in/count)
NREQ, 2, number of requesters (2..8)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester run request, level
start_val  input  NREQ*WIDTH  packed start values, requester i at [i*WIDTH +: WIDTH]
target_val  input  NREQ*WIDTH  packed target values, same packing
abort  input  1  cancel the in-flight run
gnt  output  NREQ  one-hot, 1-cycle pulse when a request is accepted
busy  output  1  high from grant until return to IDLE
done  output  1  1-cycle pulse when a run reaches its target
done_id  output  $clog2(NREQ)  requester index of the current/last run
aborted  output  1  1-cycle pulse when a run is cancelled
err  output  1  1-cycle watchdog pulse (see Optional Feature)
ctr_load  output  1  to counter load
ctr_enable  output  1  to counter enable
ctr_up_down  output  1  to counter up_down (1 = up)
ctr_d_in  output  WIDTH  to counter d_in
ctr_count  input  WIDTH  from counter count

Behaviour:
- All outputs are registered.
- Async reset (rst_n low) immediately forces:
  - state IDLE, rr_ptr 0;
  - gnt 0, busy 0, done 0, done_id 0, aborted 0, err 0;
  - ctr_load 0, ctr_enable 0, ctr_up_down 1, ctr_d_in 0.
  - An in-flight run is dropped; no done or aborted pulse.
- States: IDLE, LOAD, RUN, DONE.
- IDLE, any req high:
  - Winner = first set req bit searching from rr_ptr upward, wrapping.
  - Latch winner's start and target.
  - dir = 1 if target >= start (unsigned), else 0.
  - Next edge: gnt[winner] = 1, busy = 1, ctr_load = 1, ctr_d_in = start, ctr_up_down = dir, done_id = winner → LOAD.
- LOAD (exactly 1 cycle):
  - Counter loads start at the closing edge.
  - If target == start → DONE with ctr_enable 0.
  - Else → RUN with ctr_enable 1.
  - gnt and ctr_load return to 0.
- RUN:
  - ctr_enable = 1; ctr_up_down holds dir.
  - Stop condition: ctr_count == target-1 (up) or target+1 (down).
  - On the edge where the counter reaches target, the controller registers ctr_enable = 0 → DONE.
  - Run length is exactly |target - start| enabled cycles; the counter then holds target.
- DONE (1 cycle):
  - done = 1.
  - rr_ptr = winner+1, wrapping to 0 after NREQ-1.
  - Next edge → IDLE with busy 0. No arbitration occurs during DONE.
- Abort:
  - Applies in LOAD or RUN; sampled at the edge.
  - Next edge: ctr_enable 0, ctr_load 0, aborted = 1 for one cycle, → IDLE.
  - rr_ptr advances as for DONE; done is not pulsed.
  - Abort in IDLE or DONE is ignored.
- Requesters:
  - A request is consumed by its gnt pulse.
  - req still high after DONE is a new request.
  - start_val/target_val only need to be valid in the IDLE cycle that grants.
- Arithmetic is unsigned, WIDTH bits. Counting never wraps because stop precedes wrap.
- ctr_up_down is changed only in IDLE→LOAD.
- Latency:
  - gnt to done = |target - start| + 1 cycles.
  - Minimum request-to-regrant = |diff| + 3 cycles.

Optional Feature:
- Macro: CTR_RUN_WATCHDOG_EN.
- Defined:
  - A WIDTH+1-bit cycle counter clears on LOAD and increments each RUN cycle.
  - If it reaches 2**WIDTH while in RUN (counter disturbed externally): next edge ctr_enable 0, err = 1 for one cycle, → IDLE, no done, rr_ptr advances.
- Undefined: no watchdog logic; err is tied to 0.

Test Plan (WIDTH 4, NREQ 2, driving a real updown_counter):
- req0, start 5, target A → gnt = 01 with ctr_load = 1 and ctr_d_in = 5, ctr_enable high 5 cycles with up_down = 1, done with done_id = 0, count holds A.
- req1, start 7, target 2 → up_down = 0, enable high 5 cycles, done with done_id = 1, count = 2, enable 0 afterwards.
- req = 11 held from reset through three runs → grant order 0, 1, 0; busy never overlaps two runs.
- req0, start 3, target 3 → ctr_load 1 cycle, ctr_enable never high, done exactly 1 cycle after gnt.
- req0, start 0, target F; assert abort in the 4th RUN cycle → enable 0 the next edge, aborted pulse, no done, count frozen at 4.
- rst_n low for 2 cycles mid-RUN → all outputs at reset values immediately; then req1 → grant goes to requester 1 via the normal flow, with rr_ptr restarted at 0.
